cpu_loader: RTL and testbench
=============================

Name: cpu_loader

Overview:
Boot-time program loader that sits directly upstream of the pipelined CPU top and drives its external memory ports.
- Accepts a valid/ready word stream and writes the first imem_len words into instruction memory through addr_ext/wen_ext/wdata_ext.
- Writes the next dmem_len words into data memory through addr_ext_2/wen_ext_2/wdata_ext_2.
- Then raises cpu_enable to start execution. halt returns the block to idle.

Parameters:
- IMEM_WORDS, 512, instruction memory capacity in words.
- DMEM_WORDS, 1024, data memory capacity in words.
- ADDR_STEP, 4, byte-address increment per word.
- LEN_W, 16, width of the length inputs.

Ports:
- clk  in  1  main clock.
- arst  in  1  asynchronous reset, active-high.
- start  in  1  single-cycle pulse; begins a load; sampled only in IDLE.
- halt  in  1  forces IDLE from any state; cpu_enable drops the next cycle.
- imem_len  in  LEN_W  instruction word count, sampled on start.
- dmem_len  in  LEN_W  data word count, sampled on start.
- s_valid  in  1  stream word valid.
- s_ready  out  1  loader can accept a word.
- s_data  in  32  stream word.
- addr_ext / wen_ext / ren_ext / wdata_ext  out  32/1/1/32  instruction-memory external port.
- rdata_ext  in  32  instruction-memory read data (used by verify only).
- addr_ext_2 / wen_ext_2 / ren_ext_2 / wdata_ext_2  out  32/1/1/32  data-memory external port.
- rdata_ext_2  in  32  data-memory read data (used by verify only).
- cpu_enable  out  1  drives the CPU enable input.
- busy  out  1  high in LOAD_I, LOAD_D and verify states.
- error  out  1  high in ERROR.

Behaviour:
- Reset: all outputs are 0, state is IDLE, and the word counter is 0.
- All memory-port outputs are registered. A word accepted at edge t (s_valid && s_ready) appears at t+1 with wen=1 for exactly one cycle, addr = idx*ADDR_STEP and wdata = the accepted word. The memory then writes it at edge t+2.
- idx restarts at 0 for each region.
- Counter width is $clog2(DMEM_WORDS)+1.
- States and transitions:
  - IDLE: on start, lengths are checked and latched. If imem_len > IMEM_WORDS or dmem_len > DMEM_WORDS, go to ERROR. Otherwise go to LOAD_I; if imem_len == 0, go straight to LOAD_D; if both lengths are 0, go straight to RUN.
  - LOAD_I: s_ready=1. After the word with idx == imem_len-1 is accepted, go to LOAD_D, or to RUN if dmem_len == 0.
  - LOAD_D: s_ready=1. After the word with idx == dmem_len-1 is accepted, go to RUN.
  - RUN: cpu_enable=1 (registered; first high cycle is the cycle after entry). s_ready=0. start is ignored.
  - ERROR: s_ready=0, cpu_enable=0. Exits only via halt or arst.
- halt has priority over every other event in the same cycle, including a handshake; that word is dropped. The next state is IDLE and wen/ren are forced to 0 the next cycle.
- s_valid with s_ready low: the word is not consumed and must be held by the source.
- ren_ext and ren_ext_2 stay 0 unless verify is compiled in.
- start pulsed outside IDLE is ignored.
- Reset mid-load: all outputs clear immediately. Memory contents are left partially written.

Optional Feature:
- Macro: LOADER_VERIFY_EN.
- When defined: each write is followed by a readback.
  - The write cycle is t+1 (write lands at edge t+2).
  - t+2: ren on the same port and address, reading the just-written word.
  - Edge t+3: rdata is compared against the stored word. Mismatch → ERROR; match → continue.
  - s_ready is low from t+1 through t+3, giving one word per 4 cycles.
  - The last-word transition happens only after its compare passes.
- When undefined: no read-back, one word per cycle, ren outputs tied to 0, rdata inputs unused.

Decomposition:
- Shared package (cpu_pkg): state enum (IDLE, LOAD_I, LOAD_D, VERIFY_RD, VERIFY_CMP, RUN, ERROR), ADDR_STEP default and word width constant.
- One sub-module: loader_port_drv, the registered addr/wen/ren/wdata driver, instantiated once per memory port.

Test Plan:
- imem_len=3, dmem_len=2, words 0xA0..0xA4 streamed back-to-back → wen_ext at addrs 0,4,8 with 0xA0,0xA1,0xA2. Then wen_ext_2 at 0,4 with 0xA3,0xA4. cpu_enable rises 1 cycle after the last write cycle.
- imem_len=0, dmem_len=1 → no wen_ext pulse; single wen_ext_2 at addr 0; then RUN. Both lengths 0 → RUN 1 cycle after start.
- imem_len=513 → error=1 the cycle after start, no write strobes. halt → IDLE, error=0.
- s_valid toggled 1/0 every cycle, imem_len=4 → exactly 4 writes at addrs 0,4,8,12 with no duplicates. halt asserted with s_valid high mid-LOAD_D → that word is not written, wen low next cycle.
- Verify build: memory model corrupts rdata_ext for idx 1 → ERROR after the compare, cpu_enable stays 0. Clean model → s_ready duty of 1 in 4 and correct RUN entry.
- arst asserted in RUN for 1 cycle → cpu_enable, busy and all strobes 0 immediately. Subsequent start reloads correctly.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared definitions for the boot loader: loader state encoding, word width
// and the default byte-address step between consecutive words.
package cpu_pkg;

    localparam int WORD_W        = 32;
    localparam int ADDR_STEP_DEF = 4;

    typedef enum logic [2:0] {
        IDLE,
        LOAD_I,
        LOAD_D,
        VERIFY_RD,
        VERIFY_CMP,
        RUN,
        ERROR
    } state_t;

endpackage

// File: rtl/loader_port_drv.sv
// Registered driver for one external memory port. A write request loads
// address and data and pulses wen for one cycle; a read request pulses ren
// at the address left by the preceding write.
module loader_port_drv
    import cpu_pkg::*;
(
    input  logic              clk,
    input  logic              arst,
    input  logic              wr_req,
    input  logic              rd_req,
    input  logic [WORD_W-1:0] addr_in,
    input  logic [WORD_W-1:0] data_in,
    output logic [WORD_W-1:0] addr,
    output logic              wen,
    output logic              ren,
    output logic [WORD_W-1:0] wdata
);

    logic [WORD_W-1:0] addr_p1;
    logic [WORD_W-1:0] wdata_p1;
    logic              wen_p1;
    logic              ren_p1;

    // Strobes last one cycle; address and data hold until the next write.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            addr_p1  <= '0;
            wdata_p1 <= '0;
            wen_p1   <= 1'b0;
            ren_p1   <= 1'b0;
        end else begin
            wen_p1 <= wr_req;
            ren_p1 <= rd_req;
            if (wr_req) begin
                addr_p1  <= addr_in;
                wdata_p1 <= data_in;
            end
        end
    end

    assign addr  = addr_p1;
    assign wdata = wdata_p1;
    assign wen   = wen_p1;
    assign ren   = ren_p1;

endmodule

// File: rtl/cpu_loader.sv
// Boot-time program loader: streams imem_len words into instruction memory,
// then dmem_len words into data memory, then enables the CPU.
// Optional build macro LOADER_VERIFY_EN adds a read-back compare after each
// write (one word per four cycles); without it words load one per cycle.
module cpu_loader
    import cpu_pkg::*;
#(
    parameter int IMEM_WORDS = 512,
    parameter int DMEM_WORDS = 1024,
    parameter int ADDR_STEP  = ADDR_STEP_DEF,
    parameter int LEN_W      = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              start,
    input  logic              halt,
    input  logic [LEN_W-1:0]  imem_len,
    input  logic [LEN_W-1:0]  dmem_len,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [WORD_W-1:0] s_data,
    output logic [WORD_W-1:0] addr_ext,
    output logic              wen_ext,
    output logic              ren_ext,
    output logic [WORD_W-1:0] wdata_ext,
    input  logic [WORD_W-1:0] rdata_ext,
    output logic [WORD_W-1:0] addr_ext_2,
    output logic              wen_ext_2,
    output logic              ren_ext_2,
    output logic [WORD_W-1:0] wdata_ext_2,
    input  logic [WORD_W-1:0] rdata_ext_2,
    output logic              cpu_enable,
    output logic              busy,
    output logic              error
);

    localparam int CNT_W = $clog2(DMEM_WORDS) + 1;

    state_t            state_q, state_d;
    logic [CNT_W-1:0]  idx_q, idx_d;
    logic [LEN_W-1:0]  ilen_q, dlen_q;
    logic              cpu_enable_q;
    logic              accept;
    logic              is_last;
    logic              len_bad;
    logic [LEN_W-1:0]  cur_len;
    logic              wr_i, wr_d, rd_i, rd_d;
    logic [WORD_W-1:0] wr_addr;

`ifdef LOADER_VERIFY_EN
    logic              region_q;
    logic              last_q;
    logic              cmp_wait_q;
    logic [WORD_W-1:0] rdata_sel;
    logic [WORD_W-1:0] wdata_sel;

    assign rdata_sel = region_q ? rdata_ext_2 : rdata_ext;
    assign wdata_sel = region_q ? wdata_ext_2 : wdata_ext;
`else
    logic unused_rdata;
    assign unused_rdata = ^{rdata_ext, rdata_ext_2};
`endif

    assign s_ready = (state_q == LOAD_I) || (state_q == LOAD_D);
    assign accept  = s_valid && s_ready && !halt;
    assign cur_len = (state_q == LOAD_D) ? dlen_q : ilen_q;
    assign is_last = (LEN_W'(idx_q) + LEN_W'(1)) == cur_len;
    assign len_bad = (32'(imem_len) > 32'(IMEM_WORDS)) || (32'(dmem_len) > 32'(DMEM_WORDS));
    assign wr_addr = WORD_W'(idx_q) * WORD_W'(ADDR_STEP);

    // Next-state, word index and port request decode; halt overrides all.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wr_i    = 1'b0;
        wr_d    = 1'b0;
        rd_i    = 1'b0;
        rd_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d = '0;
                    if (len_bad)
                        state_d = ERROR;
                    else if (imem_len != '0)
                        state_d = LOAD_I;
                    else if (dmem_len != '0)
                        state_d = LOAD_D;
                    else
                        state_d = RUN;
                end
            end
            LOAD_I, LOAD_D: begin
                if (accept) begin
                    wr_i = (state_q == LOAD_I);
                    wr_d = (state_q == LOAD_D);
`ifdef LOADER_VERIFY_EN
                    state_d = VERIFY_RD;
`else
                    if (is_last) begin
                        idx_d   = '0;
                        state_d = (state_q == LOAD_I && dlen_q != '0) ? LOAD_D : RUN;
                    end else begin
                        idx_d = idx_q + CNT_W'(1);
                    end
`endif
                end
            end
`ifdef LOADER_VERIFY_EN
            VERIFY_RD: begin
                rd_i    = !region_q;
                rd_d    = region_q;
                state_d = VERIFY_CMP;
            end
            VERIFY_CMP: begin
                // First cycle waits for the registered read data; compare on the second.
                if (cmp_wait_q) begin
                    if (rdata_sel != wdata_sel) begin
                        state_d = ERROR;
                    end else if (last_q) begin
                        idx_d   = '0;
                        state_d = (!region_q && dlen_q != '0) ? LOAD_D : RUN;
                    end else begin
                        idx_d   = idx_q + CNT_W'(1);
                        state_d = region_q ? LOAD_D : LOAD_I;
                    end
                end
            end
`endif
            default: ;
        endcase
        if (halt) begin
            state_d = IDLE;
            wr_i    = 1'b0;
            wr_d    = 1'b0;
            rd_i    = 1'b0;
            rd_d    = 1'b0;
        end
    end

    // State, index, latched lengths and the registered CPU enable.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q      <= IDLE;
            idx_q        <= '0;
            ilen_q       <= '0;
            dlen_q       <= '0;
            cpu_enable_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            idx_q        <= idx_d;
            cpu_enable_q <= (state_q == RUN) && !halt;
            if (state_q == IDLE && start) begin
                ilen_q <= imem_len;
                dlen_q <= dmem_len;
            end
        end
    end

`ifdef LOADER_VERIFY_EN
    // Remember which region and whether the last word is being verified.
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            region_q   <= 1'b0;
            last_q     <= 1'b0;
            cmp_wait_q <= 1'b0;
        end else begin
            cmp_wait_q <= (state_q == VERIFY_CMP) && !cmp_wait_q && !halt;
            if (accept) begin
                region_q <= (state_q == LOAD_D);
                last_q   <= is_last;
            end
        end
    end
`endif

    loader_port_drv u_drv_i (
        .clk     (clk),
        .arst    (arst),
        .wr_req  (wr_i),
        .rd_req  (rd_i),
        .addr_in (wr_addr),
        .data_in (s_data),
        .addr    (addr_ext),
        .wen     (wen_ext),
        .ren     (ren_ext),
        .wdata   (wdata_ext)
    );

    loader_port_drv u_drv_d (
        .clk     (clk),
        .arst    (arst),
        .wr_req  (wr_d),
        .rd_req  (rd_d),
        .addr_in (wr_addr),
        .data_in (s_data),
        .addr    (addr_ext_2),
        .wen     (wen_ext_2),
        .ren     (ren_ext_2),
        .wdata   (wdata_ext_2)
    );

    assign cpu_enable = cpu_enable_q;
    assign busy       = (state_q == LOAD_I) || (state_q == LOAD_D) ||
                        (state_q == VERIFY_RD) || (state_q == VERIFY_CMP);
    assign error      = (state_q == ERROR);

endmodule

// File: tb/tb_cpu_loader.sv
// Directed testbench for cpu_loader. Works for both the default build and
// the LOADER_VERIFY_EN build (word spacing and RUN latency adapt).
module tb_cpu_loader;

`ifdef LOADER_VERIFY_EN
    localparam int GAP     = 4;
    localparam int RUN_LAT = 4;
`else
    localparam int GAP     = 1;
    localparam int RUN_LAT = 1;
`endif

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        start = 1'b0;
    logic        halt = 1'b0;
    logic [15:0] imem_len = '0;
    logic [15:0] dmem_len = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic [31:0] addr_ext, wdata_ext, addr_ext_2, wdata_ext_2;
    logic        wen_ext, ren_ext, wen_ext_2, ren_ext_2;
    logic [31:0] rdata_ext = '0;
    logic [31:0] rdata_ext_2 = '0;
    logic        cpu_enable, busy, error;

    int errors = 0;
    int checks = 0;
    logic corrupt = 1'b0;

    logic [31:0] mem_i [0:511];
    logic [31:0] mem_d [0:1023];
    logic [31:0] ia_q[$], id_q[$], da_q[$], dd_q[$];

    cpu_loader dut (
        .clk(clk), .arst(arst), .start(start), .halt(halt),
        .imem_len(imem_len), .dmem_len(dmem_len),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .addr_ext(addr_ext), .wen_ext(wen_ext), .ren_ext(ren_ext),
        .wdata_ext(wdata_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wen_ext_2(wen_ext_2), .ren_ext_2(ren_ext_2),
        .wdata_ext_2(wdata_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .error(error)
    );

    always #5 clk = ~clk;

    // Memory model with synchronous read; logs every write strobe.
    always @(posedge clk) begin
        if (wen_ext) begin
            mem_i[addr_ext[10:2]] <= wdata_ext;
            ia_q.push_back(addr_ext);
            id_q.push_back(wdata_ext);
        end
        if (wen_ext_2) begin
            mem_d[addr_ext_2[11:2]] <= wdata_ext_2;
            da_q.push_back(addr_ext_2);
            dd_q.push_back(wdata_ext_2);
        end
        if (ren_ext)
            rdata_ext <= mem_i[addr_ext[10:2]] ^ ((corrupt && addr_ext == 32'd4) ? 32'h1 : 32'h0);
        if (ren_ext_2)
            rdata_ext_2 <= mem_d[addr_ext_2[11:2]];
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_logs();
        ia_q.delete(); id_q.delete(); da_q.delete(); dd_q.delete();
    endtask

    task automatic do_start(input int il, input int dl);
        imem_len = 16'(il);
        dmem_len = 16'(dl);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic do_halt();
        halt = 1'b1;
        tick();
        halt = 1'b0;
    endtask

    // Streams n words base, base+1, ... ; reports accepts and off-spacing gaps.
    task automatic send_words(input int n, input logic [31:0] base,
                              output int acc, output int bad_gap);
        int cyc;
        int last;
        logic rdy;
        acc = 0; bad_gap = 0; cyc = 0; last = -1;
        s_valid = 1'b1;
        s_data  = base;
        while (acc < n && cyc < 200) begin
            rdy = s_ready;
            tick();
            cyc++;
            if (rdy) begin
                if (last >= 0 && (cyc - last) != GAP) bad_gap++;
                last = cyc;
                acc++;
                s_data = base + 32'(acc);
            end
        end
        s_valid = 1'b0;
    endtask

    task automatic wait_run(output int n);
        n = 0;
        while (cpu_enable !== 1'b1 && n < 50) begin
            tick();
            n++;
        end
    endtask

    task automatic test_reset();
        arst = 1'b1;
        tick(); tick();
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL reset_cpu_enable: got %b want 0", cpu_enable); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL reset_error: got %b want 0", error); end
        checks++; if (s_ready !== 1'b0) begin errors++; $display("FAIL reset_s_ready: got %b want 0", s_ready); end
        checks++; if ({wen_ext, wen_ext_2, ren_ext, ren_ext_2} !== 4'b0) begin errors++; $display("FAIL reset_strobes: got %b want 0000", {wen_ext, wen_ext_2, ren_ext, ren_ext_2}); end
        checks++; if ((addr_ext | wdata_ext | addr_ext_2 | wdata_ext_2) !== 32'h0) begin errors++; $display("FAIL reset_addr_data: got nonzero want 0"); end
        arst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int acc, bad, n;
        logic [31:0] ea [3] = '{32'd0, 32'd4, 32'd8};
        clear_logs();
        do_start(3, 2);
        checks++; if ({busy, s_ready} !== 2'b11) begin errors++; $display("FAIL basic_load_entry: busy,s_ready=%b want 11", {busy, s_ready}); end
        send_words(5, 32'hA0, acc, bad);
        checks++; if (acc !== 5) begin errors++; $display("FAIL basic_accepts: got %0d want 5", acc); end
        checks++; if (bad !== 0) begin errors++; $display("FAIL basic_spacing: %0d gaps differ from %0d", bad, GAP); end
        wait_run(n);
        checks++; if (n !== RUN_LAT) begin errors++; $display("FAIL basic_run_latency: got %0d want %0d", n, RUN_LAT); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL basic_busy_run: got %b want 0", busy); end
        checks++; if (ia_q.size() !== 3 || da_q.size() !== 2) begin errors++; $display("FAIL basic_write_count: imem=%0d dmem=%0d want 3 2", ia_q.size(), da_q.size()); end
        for (int i = 0; i < 3 && i < ia_q.size(); i++) begin
            checks++; if (ia_q[i] !== ea[i] || id_q[i] !== 32'hA0 + 32'(i)) begin errors++; $display("FAIL basic_imem_%0d: addr=%h data=%h want %h %h", i, ia_q[i], id_q[i], ea[i], 32'hA0 + 32'(i)); end
        end
        for (int i = 0; i < 2 && i < da_q.size(); i++) begin
            checks++; if (da_q[i] !== ea[i] || dd_q[i] !== 32'hA3 + 32'(i)) begin errors++; $display("FAIL basic_dmem_%0d: addr=%h data=%h want %h %h", i, da_q[i], dd_q[i], ea[i], 32'hA3 + 32'(i)); end
        end
        do_halt();
        checks++; if (cpu_enable !== 1'b0) begin errors++; $display("FAIL basic_halt_enable: got %b want 0", cpu_enable); end
    endtask

    task automatic test_zero_len();
        int acc, bad, n;
        clear_logs();
        do_start(0, 1);
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL zero_i_busy: got %b want 1", busy); end
        send_words(1, 32'hB0, acc, bad);
        wait_run(n);
        checks++; if (n !== RUN_LAT) begin errors++; $display("FAIL zero_i_run_latency: got %0d want %0d", n, RUN_LAT); end
        checks++; if (ia_q.size() !== 0 || da_q.size() !== 1) begin errors++; $display("FAIL zero_i_counts: imem=%0d dmem=%0d want 0 1", ia_q.size(), da_q.size()); end
        if (da_q.size() > 0) begin
            checks++; if (da_q[0] !== 32'd0 || dd_q[0] !== 32'hB0) begin errors++; $display("FAIL zero_i_word: addr=%h data=%h want 0 b0", da_q[0], dd_q[0]); end
        end
        do_halt();
        do_start(0, 0);
        checks++; if (busy !== 1'b0 || cpu_enable !== 1'b0) begin errors++; $display("FAIL zero_both_entry: busy=%b en=%b want 0 0", busy, cpu_enable); end
        wait_run(n);
        checks++; if (n !== 1) begin errors++; $display("FAIL zero_both_latency: got %0d want 1", n); end
        do_halt();
    endtask

    task automatic test_error();
        clear_logs();
        do_start(513, 0);
        checks++; if ({error, busy, s_ready} !== 3'b100) begin errors++; $display("FAIL err_imem_len: error,busy,s_ready=%b want 100", {error, busy, s_ready}); end
        s_valid = 1'b1; s_data = 32'hEE;
        tick(); tick(); tick();
        s_valid = 1'b0;
        checks++; if (error !== 1'b1 || cpu_enable !== 1'b0) begin errors++; $display("FAIL err_sticky: error=%b en=%b want 1 0", error, cpu_enable); end
        do_halt();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL err_halt_clear: got %b want 0", error); end
        checks++; if (ia_q.size() + da_q.size() !== 0) begin errors++; $display("FAIL err_no_writes: got %0d writes want 0", ia_q.size() + da_q.size()); end
        do_start(1, 1025);
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL err_dmem_len: got %b want 1", error); end
        do_halt();
        do_start(512, 1024);
        checks++; if ({error, busy} !== 2'b01) begin errors++; $display("FAIL err_max_len_ok: error,busy=%b want 01", {error, busy}); end
        do_halt();
    endtask

    task automatic test_toggle();
        int acc, cyc, n;
        logic rdy;
        clear_logs();
        do_start(4, 0);
        acc = 0; cyc = 0;
        while (acc < 4 && cyc < 100) begin
            s_valid = (cyc % 2 == 0);
            s_data  = 32'hC0 + 32'(acc);
            rdy = s_ready;
            tick();
            if (s_valid && rdy) acc++;
            cyc++;
        end
        s_valid = 1'b0;
        checks++; if (acc !== 4) begin errors++; $display("FAIL toggle_accepts: got %0d want 4", acc); end
        wait_run(n);
        checks++; if (n !== RUN_LAT) begin errors++; $display("FAIL toggle_run_latency: got %0d want %0d", n, RUN_LAT); end
        checks++; if (ia_q.size() !== 4) begin errors++; $display("FAIL toggle_write_count: got %0d want 4", ia_q.size()); end
        for (int i = 0; i < 4 && i < ia_q.size(); i++) begin
            checks++; if (ia_q[i] !== 32'(4 * i) || id_q[i] !== 32'hC0 + 32'(i)) begin errors++; $display("FAIL toggle_word_%0d: addr=%h data=%h want %h %h", i, ia_q[i], id_q[i], 32'(4 * i), 32'hC0 + 32'(i)); end
        end
        do_halt();
    endtask

    task automatic test_halt_load_d();
        int acc, bad, n;
        clear_logs();
        do_start(1, 3);
        send_words(2, 32'hD0, acc, bad);
        n = 0;
        while (s_ready !== 1'b1 && n < 20) begin tick(); n++; end
        checks++; if (s_ready !== 1'b1) begin errors++; $display("FAIL halt_ready_wait: s_ready=%b want 1", s_ready); end
        s_valid = 1'b1; s_data = 32'hD2; halt = 1'b1;
        tick();
        halt = 1'b0; s_valid = 1'b0;
        checks++; if ({wen_ext_2, busy, s_ready} !== 3'b000) begin errors++; $display("FAIL halt_next_cycle: wen2,busy,ready=%b want 000", {wen_ext_2, busy, s_ready}); end
        tick(); tick();
        checks++; if (da_q.size() !== 1) begin errors++; $display("FAIL halt_dmem_count: got %0d want 1", da_q.size()); end
        if (da_q.size() > 0) begin
            checks++; if (dd_q[0] !== 32'hD1) begin errors++; $display("FAIL halt_dmem_word: got %h want d1", dd_q[0]); end
        end
    endtask

    task automatic test_arst();
        int acc, bad, n;
        clear_logs();
        do_start(1, 0);
        send_words(1, 32'hE0, acc, bad);
        wait_run(n);
        checks++; if (cpu_enable !== 1'b1) begin errors++; $display("FAIL arst_pre_run: en=%b want 1", cpu_enable); end
        arst = 1'b1;
        #1;
        checks++; if ({cpu_enable, busy, wen_ext, wen_ext_2, ren_ext, ren_ext_2} !== 6'b0) begin errors++; $display("FAIL arst_immediate: en,busy,strobes=%b want 000000", {cpu_enable, busy, wen_ext, wen_ext_2, ren_ext, ren_ext_2}); end
        tick();
        arst = 1'b0;
        tick();
        clear_logs();
        do_start(2, 1);
        send_words(3, 32'hE1, acc, bad);
        wait_run(n);
        checks++; if (n !== RUN_LAT) begin errors++; $display("FAIL arst_reload_latency: got %0d want %0d", n, RUN_LAT); end
        checks++; if (ia_q.size() !== 2 || da_q.size() !== 1) begin errors++; $display("FAIL arst_reload_counts: imem=%0d dmem=%0d want 2 1", ia_q.size(), da_q.size()); end
        if (ia_q.size() == 2 && da_q.size() == 1) begin
            checks++; if (ia_q[1] !== 32'd4 || id_q[1] !== 32'hE2 || da_q[0] !== 32'd0 || dd_q[0] !== 32'hE3) begin errors++; $display("FAIL arst_reload_words: i1=%h/%h d0=%h/%h want 4/e2 0/e3", ia_q[1], id_q[1], da_q[0], dd_q[0]); end
        end
        do_halt();
    endtask

`ifdef LOADER_VERIFY_EN
    task automatic test_verify_corrupt();
        int acc, bad;
        clear_logs();
        corrupt = 1'b1;
        do_start(3, 0);
        send_words(2, 32'hF0, acc, bad);
        tick(); tick();
        checks++; if (error !== 1'b0) begin errors++; $display("FAIL verify_before_cmp: error=%b want 0", error); end
        tick();
        checks++; if (error !== 1'b1) begin errors++; $display("FAIL verify_mismatch: error=%b want 1", error); end
        tick(); tick();
        checks++; if ({cpu_enable, s_ready} !== 2'b00) begin errors++; $display("FAIL verify_stuck: en,ready=%b want 00", {cpu_enable, s_ready}); end
        corrupt = 1'b0;
        do_halt();
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_zero_len();
        test_error();
        test_toggle();
        test_halt_load_d();
        test_arst();
`ifdef LOADER_VERIFY_EN
        test_verify_corrupt();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
